light_zone_arbiter: RTL and testbench

Occupancy-driven lighting arbiter for NZ rooms sharing one ambient luminance sensor and a limited lighting power budget. Each zone runs its own Moore FSM (off / waiting / on / hold / manual). A round-robin arbiter grants waiting zones while fewer than MAX_ON zones are lit. The block sits above the per-room light control logic and drives the internal-light enables of every zone.

---
 rtl/light_zone_arbiter.sv | 177 +++++++++++++++++
 tb/tb_light_zone_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/light_zone_arbiter.sv
// Occupancy-driven lighting arbiter: per-zone Moore FSMs sharing one luminance sensor,
// with a round-robin grant that caps how many requesting zones are lit at once.
module light_zone_arbiter #(
    parameter int         NZ       = 4,
    parameter int         MAX_ON   = 2,
    parameter int         HOLD_CYC = 16,
    parameter logic [7:0] LUM_TH   = 8'd64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    lum_sen,
    input  logic [NZ-1:0] motion_sen,
    input  logic [NZ-1:0] ir_sen,
    input  logic [NZ-1:0] manual,
    output logic [NZ-1:0] int_light,
    output logic [NZ-1:0] waiting,
    output logic [2:0]    lit_count
);

    localparam int              TW        = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam int              PW        = $clog2(NZ);
    localparam logic [TW-1:0]   HOLD_LOAD = TW'(HOLD_CYC - 1);
    localparam logic [3:0]      MAX_ON_W  = 4'(MAX_ON);

    typedef enum logic [2:0] {
        ST_OFF  = 3'd0,
        ST_WAIT = 3'd1,
        ST_ON   = 3'd2,
        ST_HOLD = 3'd3,
        ST_MAN  = 3'd4
    } zone_state_e;

    zone_state_e   state_r     [NZ];
    zone_state_e   state_nxt_s [NZ];
    logic [TW-1:0] timer_r     [NZ];
    logic [TW-1:0] timer_nxt_s [NZ];
    logic [PW-1:0] rr_ptr_r;
    logic [PW-1:0] rr_nxt_s;
    logic [NZ-1:0] occ_s;
    logic [NZ-1:0] elig_s;
    logic [NZ-1:0] grant_s;
    logic [NZ-1:0] light_nxt_s;
    logic [NZ-1:0] wait_nxt_s;
    logic [NZ-1:0] int_light_r;
    logic [NZ-1:0] waiting_r;
    logic [2:0]    lit_count_r;
    logic          dark_s;
    int            best_d_s;
    int            dist_s;

    function automatic logic [2:0] popcount(input logic [NZ-1:0] v);
        logic [2:0] c;
        c = 3'd0;
        for (int i = 0; i < NZ; i++) begin
            c = c + {2'b00, v[i]};
        end
        return c;
    endfunction

    assign occ_s  = motion_sen & ir_sen;
    assign dark_s = (lum_sen < LUM_TH);

    // Zones that could take a grant this cycle
    always_comb begin
        elig_s = {NZ{1'b0}};
        for (int i = 0; i < NZ; i++) begin
            elig_s[i] = (state_r[i] == ST_WAIT) & occ_s[i] & dark_s & ~manual[i];
        end
    end

    // Round-robin grant: nearest eligible zone at or above rr_ptr, budget from registered count
    always_comb begin
        grant_s  = {NZ{1'b0}};
        rr_nxt_s = rr_ptr_r;
        best_d_s = NZ;
        dist_s   = 0;
        if ({1'b0, lit_count_r} < MAX_ON_W) begin
            for (int i = 0; i < NZ; i++) begin
                dist_s = i - int'(rr_ptr_r);
                dist_s = (dist_s < 0) ? dist_s + NZ : dist_s;
                if (elig_s[i] && (dist_s < best_d_s)) begin
                    best_d_s   = dist_s;
                    grant_s    = {NZ{1'b0}};
                    grant_s[i] = 1'b1;
                    rr_nxt_s   = PW'((i + 1) % NZ);
                end else begin
                    best_d_s = best_d_s;
                end
            end
        end else begin
            grant_s = {NZ{1'b0}};
        end
    end

    // Per-zone next state; manual first, then brightness, then occupancy/timer
    always_comb begin
        for (int i = 0; i < NZ; i++) begin
            state_nxt_s[i] = state_r[i];
            timer_nxt_s[i] = timer_r[i];
            case (state_r[i])
                ST_OFF: begin
                    if (manual[i])                 state_nxt_s[i] = ST_MAN;
                    else if (occ_s[i] && dark_s)   state_nxt_s[i] = ST_WAIT;
                    else                           state_nxt_s[i] = ST_OFF;
                end
                ST_WAIT: begin
                    if (manual[i])                 state_nxt_s[i] = ST_MAN;
                    else if (!(occ_s[i] && dark_s)) state_nxt_s[i] = ST_OFF;
                    else if (grant_s[i])           state_nxt_s[i] = ST_ON;
                    else                           state_nxt_s[i] = ST_WAIT;
                end
                ST_ON: begin
                    if (manual[i])                 state_nxt_s[i] = ST_MAN;
                    else if (!dark_s)              state_nxt_s[i] = ST_OFF;
                    else if (!occ_s[i]) begin
                        state_nxt_s[i] = ST_HOLD;
                        timer_nxt_s[i] = HOLD_LOAD;
                    end else                       state_nxt_s[i] = ST_ON;
                end
                ST_HOLD: begin
                    if (manual[i])                 state_nxt_s[i] = ST_MAN;
                    else if (!dark_s)              state_nxt_s[i] = ST_OFF;
                    else if (occ_s[i])             state_nxt_s[i] = ST_ON;
                    else if (timer_r[i] == {TW{1'b0}}) state_nxt_s[i] = ST_OFF;
                    else                           timer_nxt_s[i] = timer_r[i] - {{(TW-1){1'b0}}, 1'b1};
                end
                ST_MAN: begin
                    if (!manual[i])                state_nxt_s[i] = ST_OFF;
                    else                           state_nxt_s[i] = ST_MAN;
                end
                default: begin
                    state_nxt_s[i] = ST_OFF;
                    timer_nxt_s[i] = {TW{1'b0}};
                end
            endcase
        end
    end

    // Output decode of the next state so the registered outputs track the state register
    always_comb begin
        light_nxt_s = {NZ{1'b0}};
        wait_nxt_s  = {NZ{1'b0}};
        for (int i = 0; i < NZ; i++) begin
            light_nxt_s[i] = (state_nxt_s[i] == ST_ON) || (state_nxt_s[i] == ST_HOLD) ||
                             (state_nxt_s[i] == ST_MAN);
            wait_nxt_s[i]  = (state_nxt_s[i] == ST_WAIT);
        end
    end

    // State, timers, pointer and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NZ; i++) begin
                state_r[i] <= ST_OFF;
                timer_r[i] <= {TW{1'b0}};
            end
            rr_ptr_r    <= {PW{1'b0}};
            int_light_r <= {NZ{1'b0}};
            waiting_r   <= {NZ{1'b0}};
            lit_count_r <= 3'd0;
        end else begin
            for (int i = 0; i < NZ; i++) begin
                state_r[i] <= state_nxt_s[i];
                timer_r[i] <= timer_nxt_s[i];
            end
            rr_ptr_r    <= rr_nxt_s;
            int_light_r <= light_nxt_s;
            waiting_r   <= wait_nxt_s;
            lit_count_r <= popcount(light_nxt_s);
        end
    end

    assign int_light = int_light_r;
    assign waiting   = waiting_r;
    assign lit_count = lit_count_r;

endmodule

// File: tb/tb_light_zone_arbiter.sv
// Self-checking bench for light_zone_arbiter: directed table, corner sequences,
// and randomized traffic compared against a behavioural zone model.
module tb_light_zone_arbiter;

    localparam int NZ   = 4;
    localparam int HOLD = 16;
    localparam int Z_OFF = 0, Z_WAIT = 1, Z_ON = 2, Z_HOLD = 3, Z_MAN = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    lum_sen;
    logic [NZ-1:0] motion_sen, ir_sen, manual;
    logic [NZ-1:0] int_light, waiting;
    logic [2:0]    lit_count;

    int n_checks = 0;
    int n_pass   = 0;

    int m_st [NZ];
    int m_hold [NZ];
    int m_rr;

    typedef struct {
        logic       rst;
        logic [7:0] lum;
        logic [3:0] mot;
        logic [3:0] ir;
        logic [3:0] man;
        logic [3:0] e_light;
        logic [3:0] e_wait;
        logic [2:0] e_cnt;
    } vec_t;

    vec_t tbl [12];

    light_zone_arbiter #(.NZ(NZ), .MAX_ON(2), .HOLD_CYC(HOLD), .LUM_TH(8'd64)) dut (
        .clk(clk), .reset(reset), .lum_sen(lum_sen), .motion_sen(motion_sen),
        .ir_sen(ir_sen), .manual(manual), .int_light(int_light), .waiting(waiting),
        .lit_count(lit_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit is_lit(input int s);
        return (s == Z_ON) || (s == Z_HOLD) || (s == Z_MAN);
    endfunction

    // Advance the model by one clock edge using the inputs the DUT just sampled
    task automatic model_edge();
        int  lit = 0;
        int  g   = -1;
        bit  dark;
        bit  occ [NZ];
        if (!reset) begin
            for (int i = 0; i < NZ; i++) begin m_st[i] = Z_OFF; m_hold[i] = 0; end
            m_rr = 0;
            return;
        end
        dark = (lum_sen < 8'd64);
        for (int i = 0; i < NZ; i++) begin
            occ[i] = motion_sen[i] && ir_sen[i];
            if (is_lit(m_st[i])) lit++;
        end
        if (lit < 2) begin
            for (int k = 0; k < NZ && g < 0; k++) begin
                int z = (m_rr + k) % NZ;
                if (m_st[z] == Z_WAIT && occ[z] && dark && !manual[z]) g = z;
            end
        end
        if (g >= 0) m_rr = (g + 1) % NZ;
        for (int i = 0; i < NZ; i++) begin
            if (m_st[i] == Z_MAN) m_st[i] = manual[i] ? Z_MAN : Z_OFF;
            else if (manual[i]) m_st[i] = Z_MAN;
            else if (m_st[i] == Z_OFF) begin
                if (occ[i] && dark) m_st[i] = Z_WAIT;
            end
            else if (!dark) m_st[i] = Z_OFF;
            else if (m_st[i] == Z_WAIT) begin
                if (!occ[i]) m_st[i] = Z_OFF;
                else if (g == i) m_st[i] = Z_ON;
            end
            else if (m_st[i] == Z_ON) begin
                if (!occ[i]) begin m_st[i] = Z_HOLD; m_hold[i] = HOLD; end
            end
            else begin
                if (occ[i]) m_st[i] = Z_ON;
                else if (m_hold[i] == 1) m_st[i] = Z_OFF;
                else m_hold[i]--;
            end
        end
    endtask

    task automatic tick();
        int el = 0, ew = 0, ec = 0;
        @(posedge clk);
        #1;
        model_edge();
        for (int i = 0; i < NZ; i++) begin
            if (is_lit(m_st[i])) begin el |= (1 << i); ec++; end
            if (m_st[i] == Z_WAIT) ew |= (1 << i);
        end
        chk("model_light", int'(int_light), el);
        chk("model_wait",  int'(waiting),   ew);
        chk("model_count", int'(lit_count), ec);
    endtask

    task automatic drive(input logic r, input logic [7:0] l, input logic [3:0] m,
                         input logic [3:0] i, input logic [3:0] mn);
        reset = r; lum_sen = l; motion_sen = m; ir_sen = i; manual = mn;
    endtask

    task automatic expect3(input string name, input int el, input int ew, input int ec);
        chk({name, "_light"}, int'(int_light), el);
        chk({name, "_wait"},  int'(waiting),   ew);
        chk({name, "_count"}, int'(lit_count), ec);
    endtask

    initial begin
        tbl[0]  = '{1'b0, 8'd8,   4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 3'd0};
        tbl[1]  = '{1'b0, 8'd8,   4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 3'd0};
        tbl[2]  = '{1'b0, 8'd8,   4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 3'd0};
        tbl[3]  = '{1'b1, 8'd8,   4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 3'd4};
        tbl[4]  = '{1'b1, 8'd200, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 3'd0};
        tbl[5]  = '{1'b1, 8'd200, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 3'd0};
        tbl[6]  = '{1'b1, 8'd8,   4'h1, 4'h1, 4'h0, 4'h0, 4'h1, 3'd0};
        tbl[7]  = '{1'b1, 8'd8,   4'h1, 4'h1, 4'h0, 4'h1, 4'h0, 3'd1};
        tbl[8]  = '{1'b1, 8'd8,   4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 3'd1};
        tbl[9]  = '{1'b1, 8'd200, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 3'd0};
        tbl[10] = '{1'b1, 8'd8,   4'h1, 4'h1, 4'h2, 4'h2, 4'h1, 3'd1};
        tbl[11] = '{1'b1, 8'd8,   4'h1, 4'h1, 4'h2, 4'h3, 4'h0, 3'd2};

        for (int n = 0; n < 12; n++) begin
            drive(tbl[n].rst, tbl[n].lum, tbl[n].mot, tbl[n].ir, tbl[n].man);
            tick();
            expect3($sformatf("tbl%0d", n), int'(tbl[n].e_light), int'(tbl[n].e_wait),
                    int'(tbl[n].e_cnt));
        end

        // Budget contention: all zones occupied from reset
        drive(1'b0, 8'd8, 4'h0, 4'h0, 4'h0); tick();
        drive(1'b1, 8'd8, 4'hF, 4'hF, 4'h0);
        tick(); expect3("cont_req",   0, 15, 0);
        tick(); expect3("cont_g0",    1, 14, 1);
        tick(); expect3("cont_g1",    3, 12, 2);
        for (int n = 0; n < 4; n++) tick();
        expect3("cont_full", 3, 12, 2);
        motion_sen = 4'hE;
        for (int n = 0; n < HOLD; n++) begin
            tick();
            chk($sformatf("cont_hold%0d", n), int'(int_light[0]), 1);
        end
        tick(); expect3("cont_off0", 2, 12, 1);
        tick(); expect3("cont_g2",   6, 8, 2);

        // Manual zone over budget
        drive(1'b0, 8'd8, 4'h0, 4'h0, 4'h0); tick();
        drive(1'b1, 8'd8, 4'h7, 4'hF, 4'h0);
        tick(); tick(); tick();
        expect3("man_base", 3, 4, 2);
        manual = 4'h8;
        tick(); expect3("man_on", 11, 4, 3);
        tick(); tick();
        expect3("man_nogrant", 11, 4, 3);
        manual = 4'h0;
        tick(); expect3("man_off", 3, 4, 2);
        tick(); expect3("man_full", 3, 4, 2);

        // Re-occupancy during hold, then brightening with a manual zone
        drive(1'b0, 8'd8, 4'h0, 4'h0, 4'h0); tick();
        drive(1'b1, 8'd8, 4'h1, 4'h1, 4'h0);
        tick(); tick();
        expect3("reocc_on", 1, 0, 1);
        ir_sen = 4'h0;
        for (int n = 0; n < 5; n++) tick();
        chk("reocc_hold5", int'(int_light), 1);
        ir_sen = 4'h1;
        for (int n = 0; n < 20; n++) tick();
        expect3("reocc_stay", 1, 0, 1);
        manual = 4'h2;
        tick(); expect3("bright_pre", 3, 0, 2);
        lum_sen = 8'd200;
        tick(); expect3("bright_post", 2, 0, 1);

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            reset      = ($urandom_range(0, 99) != 0);
            lum_sen    = ($urandom_range(0, 9) == 0) ? 8'd200 : 8'($urandom_range(0, 80));
            motion_sen = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
            ir_sen     = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
            manual     = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
